// File: rtl/ray_slab_accum.sv
// Ray-AABB slab accumulator: folds NAXIS (t_near, t_far) beats per ray into
// t_entry = max(t_near), t_exit = min(t_far), then issues a registered hit verdict.
module ray_slab_accum #(
  parameter int WE    = 11,
  parameter int WF    = 18,
  parameter int NAXIS = 3,
  localparam int W    = WE + WF + 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] t_near,
  input  logic [W-1:0] t_far,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         hit,
  output logic         nan_flag,
  output logic [W-1:0] t_entry,
  output logic [W-1:0] t_exit
);

  localparam int CW = (NAXIS > 1) ? $clog2(NAXIS) : 1;

  typedef enum logic [1:0] {ACC, RES, OUT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  acc_near;
  logic [W-1:0]  acc_far;
  logic          nan_seen;

  // Maps a non-NaN float onto a signed integer whose natural order matches the
  // float order: zero < normal < inf in magnitude, sign negates, so +0 == -0.
  function automatic logic signed [W-1:0] fkey(input logic [W-1:0] x);
    logic [W-2:0]        mag;
    logic signed [W-1:0] pos;
    mag = '0;
    case (x[W-1:W-2])
      2'b01:   mag = {2'b01, x[W-4:0]};
      2'b10:   mag = {2'b10, {(W-3){1'b0}}};
      default: mag = '0;
    endcase
    pos = $signed({1'b0, mag});
    fkey = x[W-3] ? -pos : pos;
  endfunction

  function automatic logic is_nan(input logic [W-1:0] x);
    is_nan = (x[W-1:W-2] == 2'b11);
  endfunction

  logic signed [W-1:0] k_acc_near, k_acc_far, k_tn, k_tf;
  logic [W-1:0]        near_nxt, far_nxt;
  logic                nan_nxt;
  logic                first_beat, last_beat, accept;
  logic                hit_nxt;

  assign k_acc_near = fkey(acc_near);
  assign k_acc_far  = fkey(acc_far);
  assign k_tn       = fkey(t_near);
  assign k_tf       = fkey(t_far);

  assign accept     = in_valid && in_ready;
  assign first_beat = (cnt == '0);
  assign last_beat  = (cnt == CW'(NAXIS - 1));

  always_comb begin
    near_nxt = acc_near;
    far_nxt  = acc_far;
    nan_nxt  = is_nan(t_near) || is_nan(t_far);
    if (first_beat) begin
      near_nxt = t_near;
      far_nxt  = t_far;
    end else begin
      if (k_tn > k_acc_near) near_nxt = t_near;
      if (k_tf < k_acc_far)  far_nxt  = t_far;
      nan_nxt = nan_nxt || nan_seen;
    end
  end

  assign hit_nxt = !nan_seen && (k_acc_near <= k_acc_far) && (k_acc_far >= 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      hit       <= 1'b0;
      nan_flag  <= 1'b0;
      t_entry   <= '0;
      t_exit    <= '0;
      acc_near  <= '0;
      acc_far   <= '0;
      nan_seen  <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc_near <= near_nxt;
            acc_far  <= far_nxt;
            nan_seen <= nan_nxt;
            if (last_beat) begin
              cnt      <= '0;
              in_ready <= 1'b0;
              state    <= RES;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RES: begin
          hit       <= hit_nxt;
          t_entry   <= acc_near;
          t_exit    <= acc_far;
          nan_flag  <= nan_seen;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACC;
          end
        end
        default: begin
          state     <= ACC;
          cnt       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ray_slab_accum.sv
// Directed bench for ray_slab_accum: table of whole-ray vectors plus
// hand-written backpressure and mid-ray reset sequences.
module tb_ray_slab_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] t_near;
  logic [31:0] t_far;
  logic        out_valid;
  logic        out_ready;
  logic        hit;
  logic        nan_flag;
  logic [31:0] t_entry;
  logic [31:0] t_exit;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ray_slab_accum #(.WE(11), .WF(18), .NAXIS(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .t_near(t_near), .t_far(t_far),
    .out_valid(out_valid), .out_ready(out_ready),
    .hit(hit), .nan_flag(nan_flag),
    .t_entry(t_entry), .t_exit(t_exit)
  );

  localparam logic [31:0] P1   = 32'h4FFC0000;  // 1.0
  localparam logic [31:0] P3   = 32'h50020000;  // 3.0
  localparam logic [31:0] PH   = 32'h4FF80000;  // 0.5
  localparam logic [31:0] P2   = 32'h50000000;  // 2.0
  localparam logic [31:0] N1   = 32'h6FFC0000;  // -1.0
  localparam logic [31:0] ZERO = 32'h00000000;
  localparam logic [31:0] PINF = 32'h80000000;
  localparam logic [31:0] QNAN = 32'hC0000000;

  typedef struct {
    logic [31:0] n0, n1, n2;
    logic [31:0] f0, f1, f2;
    logic        hit;
    logic        nan;
    logic        chk_t;
    logic [31:0] te, tx;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] n, input logic [31:0] f);
    int budget;
    @(negedge clk);
    in_valid = 1'b1;
    t_near   = n;
    t_far    = f;
    budget   = 0;
    while (!in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL beat_wait: in_ready stuck at 0 after %0d cycles", budget);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Sends one ray; after the final acceptance edge checks the one-cycle gap
  // and then the verdict on the cycle after.
  task automatic send_ray(input vec_t v, input string nm);
    send_beat(v.n0, v.f0);
    send_beat(v.n1, v.f1);
    send_beat(v.n2, v.f2);
    @(negedge clk);
    check({nm, ".ov_gap"}, {31'd0, out_valid}, 32'd0);
    check({nm, ".rdy_gap"}, {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check({nm, ".ov"}, {31'd0, out_valid}, 32'd1);
    check({nm, ".hit"}, {31'd0, hit}, {31'd0, v.hit});
    check({nm, ".nan"}, {31'd0, nan_flag}, {31'd0, v.nan});
    if (v.chk_t) begin
      check({nm, ".t_entry"}, t_entry, v.te);
      check({nm, ".t_exit"}, t_exit, v.tx);
    end
  endtask

  task automatic take_verdict(input string nm);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({nm, ".ov_drop"}, {31'd0, out_valid}, 32'd0);
    check({nm, ".rdy_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_zero(input string nm);
    check({nm, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    check({nm, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    check({nm, ".hit"}, {31'd0, hit}, 32'd0);
    check({nm, ".nan"}, {31'd0, nan_flag}, 32'd0);
    check({nm, ".t_entry"}, t_entry, 32'd0);
    check({nm, ".t_exit"}, t_exit, 32'd0);
  endtask

  initial begin
    vecs[0] = '{n0:P1,   n1:PH, n2:N1,   f0:P3, f1:P2,   f2:P3,   hit:1, nan:0, chk_t:1, te:P1, tx:P2};
    vecs[1] = '{n0:P2,   n1:PH, n2:ZERO, f0:P3, f1:P1,   f2:PINF, hit:0, nan:0, chk_t:1, te:P2, tx:P1};
    vecs[2] = '{n0:N1,   n1:N1, n2:N1,   f0:N1, f1:N1,   f2:N1,   hit:0, nan:0, chk_t:1, te:N1, tx:N1};
    vecs[3] = '{n0:P1,   n1:P1, n2:P1,   f0:P1, f1:P1,   f2:P1,   hit:1, nan:0, chk_t:1, te:P1, tx:P1};
    vecs[4] = '{n0:P1,   n1:PH, n2:N1,   f0:P3, f1:QNAN, f2:P3,   hit:0, nan:1, chk_t:0, te:0,  tx:0};
    vecs[5] = '{n0:P1,   n1:PH, n2:N1,   f0:P3, f1:P2,   f2:P3,   hit:1, nan:0, chk_t:1, te:P1, tx:P2};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; t_near = '0; t_far = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      send_ray(vecs[i], $sformatf("vec%0d", i));
      take_verdict($sformatf("vec%0d", i));
    end

    // Backpressure: verdict held for 5 cycles, then back-to-back miss ray.
    send_ray(vecs[0], "bp");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d.ov", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_hold%0d.rdy", c), {31'd0, in_ready}, 32'd0);
      check($sformatf("bp_hold%0d.hit", c), {31'd0, hit}, 32'd1);
      check($sformatf("bp_hold%0d.te", c), t_entry, P1);
      check($sformatf("bp_hold%0d.tx", c), t_exit, P2);
    end
    take_verdict("bp");
    send_ray(vecs[1], "bp_next");
    take_verdict("bp_next");

    // Mid-ray reset: two miss-case beats, which would leave entry at 2.0 if stale.
    send_beat(P2, P3);
    send_beat(PH, P1);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check_zero("rst_mid_async");
    @(negedge clk);
    rst = 1'b0;
    check_zero("rst_mid");
    send_ray(vecs[0], "post_rst");
    take_verdict("post_rst");

    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
